heap_interval_table: RTL



---
 rtl/heap_interval_table.sv | 89 ++++++++
 1 files changed

// File: rtl/heap_interval_table.sv
// heap_interval_table: N-entry circular table of protected heap intervals with single-cycle range lookup.
// Define HEAP_TABLE_MERGE_EN to fold an overlapping/abutting write into the newest entry instead of allocating.
module heap_interval_table #(
    parameter int N     = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_write_i,
    input  logic [31:0]      addr_first_i,
    input  logic [31:0]      addr_last_i,
    input  logic [31:0]      find_addr_i,
    output logic             addr_in_range_o,
    input  logic [IDX_W-1:0] read_idx_i,
    output logic [31:0]      read_o,
    output logic [31:0]      read2_o,
    output logic [IDX_W:0]   count_o,
    output logic             full_o
);
    logic [N-1:0]     valid;
    logic [31:0]      first [N];
    logic [31:0]      last  [N];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] prev_ptr;
    logic [IDX_W:0]   count;
    logic             accept;
    logic             merge;
    logic [31:0]      new_first;
    logic [31:0]      new_last;

    assign accept   = en_write_i & ~clr_i & (addr_first_i <= addr_last_i);
    assign prev_ptr = (wr_ptr == '0) ? IDX_W'(N - 1) : wr_ptr - 1'b1;
    assign count_o  = count;
    assign full_o   = count == (IDX_W + 1)'(N);

`ifdef HEAP_TABLE_MERGE_EN
    // 33-bit sums keep last = 0xFFFFFFFF from wrapping into a false abut
    assign merge     = (count != '0) & valid[prev_ptr]
                     & ({1'b0, addr_first_i} <= {1'b0, last[prev_ptr]} + 33'd1)
                     & ({1'b0, first[prev_ptr]} <= {1'b0, addr_last_i} + 33'd1);
    assign new_first = (addr_first_i < first[prev_ptr]) ? addr_first_i : first[prev_ptr];
    assign new_last  = (addr_last_i > last[prev_ptr]) ? addr_last_i : last[prev_ptr];
`else
    assign merge     = 1'b0;
    assign new_first = addr_first_i;
    assign new_last  = addr_last_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < N; i++) begin
                first[i] <= '0;
                last[i]  <= '0;
            end
        end else if (clr_i) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            if (merge) begin
                first[prev_ptr] <= new_first;
                last[prev_ptr]  <= new_last;
            end else begin
                valid[wr_ptr] <= 1'b1;
                first[wr_ptr] <= new_first;
                last[wr_ptr]  <= new_last;
                wr_ptr        <= (wr_ptr == IDX_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
                count         <= full_o ? count : count + 1'b1;
            end
        end
    end

    always_comb begin
        addr_in_range_o = 1'b0;
        read_o          = '0;
        read2_o         = '0;
        for (int i = 0; i < N; i++) begin
            addr_in_range_o = addr_in_range_o | (valid[i] & (first[i] <= find_addr_i) & (find_addr_i <= last[i]));
            if (valid[i] && read_idx_i == IDX_W'(i)) begin
                read_o  = first[i];
                read2_o = last[i];
            end
        end
    end
endmodule
